// File: rtl/sram_pkg.sv
// Shared constants and request record for the SRAM front-end.
// The SRAM macro geometry is fixed, so widths live here rather than as top parameters.
package sram_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// Request, response and SRAM-side signals of the controller bundled together.
// slave is the controller's view; master is the view of whatever surrounds it.
interface sram_ctrl_if;
  import sram_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  req_t                  req;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic                  sram_wren;
  logic [DATA_WIDTH-1:0] sram_rdata;

  modport slave (
    input  req_valid, req, rsp_ready, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, sram_addr, sram_wdata, sram_wren
  );

  modport master (
    output req_valid, req, rsp_ready, sram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, sram_addr, sram_wdata, sram_wren
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Small circular FIFO holding captured read data until the consumer takes it.
// Callers guarantee no push when full and no pop when empty.
module sram_rsp_fifo #(
  parameter  int DEPTH = 3,
  parameter  int WIDTH = 8,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [OCC_W-1:0] occ_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    occ_d   = occ_q;
    if (push_i) wrPtr_d = nextPtr(wrPtr_q);
    if (pop_i)  rdPtr_d = nextPtr(rdPtr_q);
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      occ_q   <= '0;
    end else begin
      if (push_i) mem_q[wrPtr_q] <= data_i;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      occ_q   <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rdPtr_q];

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready front-end for the 16x8 single-port SRAM: credit-based request
// acceptance, capture of the registered read data, and saturating counters.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int RSP_DEPTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_ctrl_if.slave           bus,
  output logic [CNT_WIDTH-1:0] rd_count_o,
  output logic [CNT_WIDTH-1:0] wr_count_o
);

  localparam int OCC_W = $clog2(RSP_DEPTH + 1);

  logic [OCC_W-1:0]     occ;
  logic [OCC_W:0]       creditUsed;
  logic                 accept, rdAccept, wrAccept, pop;
  logic                 rdPending_q, rdPending_d;
  logic [CNT_WIDTH-1:0] rdCount_q, rdCount_d;
  logic [CNT_WIDTH-1:0] wrCount_q, wrCount_d;

  // A read in flight reserves a FIFO slot, so the FIFO can never overflow.
  assign creditUsed    = {1'b0, occ} + {{OCC_W{1'b0}}, rdPending_q};
  assign bus.req_ready = creditUsed < (OCC_W + 1)'(RSP_DEPTH);

  assign accept   = bus.req_valid & bus.req_ready;
  assign rdAccept = accept & ~bus.req.we;
  assign wrAccept = accept & bus.req.we;

  assign bus.sram_addr  = bus.req.addr;
  assign bus.sram_wdata = bus.req.wdata;
  assign bus.sram_wren  = wrAccept;

  assign bus.rsp_valid = (occ != '0);
  assign pop           = bus.rsp_valid & bus.rsp_ready;

  always_comb begin
    rdPending_d = rdAccept;
    rdCount_d   = rdCount_q;
    wrCount_d   = wrCount_q;
    if (rdAccept && (rdCount_q != '1)) rdCount_d = rdCount_q + 1'b1;
    if (wrAccept && (wrCount_q != '1)) wrCount_d = wrCount_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPending_q <= 1'b0;
      rdCount_q   <= '0;
      wrCount_q   <= '0;
    end else begin
      rdPending_q <= rdPending_d;
      rdCount_q   <= rdCount_d;
      wrCount_q   <= wrCount_d;
    end
  end

  // SRAM read data is valid exactly one edge after the read was accepted.
  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (rdPending_q),
    .pop_i  (pop),
    .data_i (bus.sram_rdata),
    .occ_o  (occ),
    .head_o (bus.rsp_rdata)
  );

  assign rd_count_o = rdCount_q;
  assign wr_count_o = wrCount_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural 16x8 SRAM and a read scoreboard.
// A second instance with 4-bit counters exercises counter saturation.
module tb_sram_ctrl;

  logic clk;
  logic rst_n;

  logic [15:0] rdCount, wrCount;
  logic [3:0]  rdCountSat, wrCountSat;

  sram_ctrl_if bus();
  sram_ctrl_if satBus();

  sram_ctrl #(.RSP_DEPTH(3), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .rd_count_o (rdCount),
    .wr_count_o (wrCount)
  );

  sram_ctrl #(.RSP_DEPTH(3), .CNT_WIDTH(4)) dutSat (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (satBus),
    .rd_count_o (rdCountSat),
    .wr_count_o (wrCountSat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SRAM: registered read, RDATA held during writes.
  logic [7:0] sramMem [16] = '{default: 8'h00};
  initial bus.sram_rdata = 8'h00;
  always @(posedge clk) begin
    if (bus.sram_wren) sramMem[bus.sram_addr] <= bus.sram_wdata;
    else               bus.sram_rdata <= sramMem[bus.sram_addr];
  end

  typedef struct {
    logic       valid;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       rspReady;
    logic       expReady;
    logic       expWren;
    logic       expRspValid;
    logic [7:0] expRdata;
  } vec_t;

  vec_t vecs [11];

  int         compareCount  = 0;
  int         mismatchCount = 0;
  int         cyc           = 0;
  logic       lastAccept;
  logic [7:0] modelMem [16];
  logic [7:0] expQ [$];
  int         respCycles [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle at the falling edge, then score any response handshake.
  task automatic applyStimulus(input logic valid, input logic we, input logic [3:0] addr,
                               input logic [7:0] wdata, input logic rspReady);
    logic [7:0] expData;
    @(negedge clk);
    cyc++;
    bus.req_valid = valid;
    bus.req.we    = we;
    bus.req.addr  = addr;
    bus.req.wdata = wdata;
    bus.rsp_ready = rspReady;
    #1;
    if (bus.rsp_valid && bus.rsp_ready) begin
      respCycles.push_back(cyc);
      if (expQ.size() == 0) checkOutput("unexpectedRsp", {31'd0, bus.rsp_valid}, 32'd0);
      else begin
        expData = expQ.pop_front();
        checkOutput("rspData", {24'd0, bus.rsp_rdata}, {24'd0, expData});
      end
    end
    lastAccept = valid && bus.req_ready;
    if (lastAccept && we)  modelMem[addr] = wdata;
    if (lastAccept && !we) expQ.push_back(modelMem[addr]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
  endtask

  function automatic vec_t mkVec(input logic v, input logic we, input logic [3:0] a,
                                 input logic [7:0] d, input logic rr, input logic er,
                                 input logic ew, input logic erv, input logic [7:0] erd);
    vec_t t;
    t.valid = v; t.we = we; t.addr = a; t.wdata = d; t.rspReady = rr;
    t.expReady = er; t.expWren = ew; t.expRspValid = erv; t.expRdata = erd;
    return t;
  endfunction

  int issued;

  initial begin
    vecs[0]  = mkVec(1, 1, 4'd5, 8'hA5, 1, 1, 1, 0, 8'h00);
    vecs[1]  = mkVec(1, 0, 4'd5, 8'h00, 1, 1, 0, 0, 8'h00);
    vecs[2]  = mkVec(0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 8'h00);
    vecs[3]  = mkVec(0, 0, 4'd0, 8'h00, 1, 1, 0, 1, 8'hA5);
    vecs[4]  = mkVec(1, 1, 4'd7, 8'h3C, 1, 1, 1, 0, 8'h00);
    vecs[5]  = mkVec(1, 0, 4'd7, 8'h00, 1, 1, 0, 0, 8'h00);
    vecs[6]  = mkVec(1, 1, 4'd7, 8'hC3, 1, 1, 1, 0, 8'h00);
    vecs[7]  = mkVec(1, 0, 4'd7, 8'h00, 1, 1, 0, 1, 8'h3C);
    vecs[8]  = mkVec(0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 8'h00);
    vecs[9]  = mkVec(0, 0, 4'd0, 8'h00, 1, 1, 0, 1, 8'hC3);
    vecs[10] = mkVec(0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 8'h00);

    for (int i = 0; i < 16; i++) modelMem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req = '0; bus.rsp_ready = 1'b1;
    satBus.req_valid = 1'b0; satBus.req = '0; satBus.rsp_ready = 1'b1; satBus.sram_rdata = 8'h00;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstRspValid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("rstRspRdata", {24'd0, bus.rsp_rdata}, 32'd0);
    checkOutput("rstRdCount", {16'd0, rdCount}, 32'd0);
    checkOutput("rstWrCount", {16'd0, wrCount}, 32'd0);
    checkOutput("rstReqReady", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Write/read latency and read-then-write ordering.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rspReady);
      checkOutput($sformatf("vec%0d.reqReady", i), {31'd0, bus.req_ready}, {31'd0, vecs[i].expReady});
      checkOutput($sformatf("vec%0d.wren", i), {31'd0, bus.sram_wren}, {31'd0, vecs[i].expWren});
      checkOutput($sformatf("vec%0d.rspValid", i), {31'd0, bus.rsp_valid}, {31'd0, vecs[i].expRspValid});
      if (vecs[i].expRspValid)
        checkOutput($sformatf("vec%0d.rspRdata", i), {24'd0, bus.rsp_rdata}, {24'd0, vecs[i].expRdata});
      if (vecs[i].valid)
        checkOutput($sformatf("vec%0d.sramAddr", i), {28'd0, bus.sram_addr}, {28'd0, vecs[i].addr});
      if (i == 3) begin
        checkOutput("wrCountAfterPair", {16'd0, wrCount}, 32'd1);
        checkOutput("rdCountAfterPair", {16'd0, rdCount}, 32'd1);
      end
    end
    checkOutput("wrCountTable", {16'd0, wrCount}, 32'd3);
    checkOutput("rdCountTable", {16'd0, rdCount}, 32'd3);

    // Full-throughput back-to-back reads.
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b1, 1'b1, 4'(a), 8'(a * 8'h11), 1'b1);
      checkOutput("fillReady", {31'd0, bus.req_ready}, 32'd1);
    end
    respCycles.delete();
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b1, 1'b0, 4'(a), 8'h00, 1'b1);
      checkOutput("streamReady", {31'd0, bus.req_ready}, 32'd1);
    end
    idle(4);
    checkOutput("streamRspCount", respCycles.size(), 32'd16);
    for (int i = 1; i < respCycles.size(); i++)
      checkOutput("streamRspGap", respCycles[i] - respCycles[i-1], 32'd1);

    // Backpressure: only RSP_DEPTH reads fit while the consumer stalls.
    respCycles.delete();
    issued = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b0, 4'(8 + issued), 8'h00, 1'b0);
      if (lastAccept) issued++;
      checkOutput("stallWren", {31'd0, bus.sram_wren}, 32'd0);
    end
    checkOutput("stallAccepted", issued, 32'd3);
    checkOutput("stallReqReady", {31'd0, bus.req_ready}, 32'd0);
    for (int c = 0; c < 20 && issued < 5; c++) begin
      applyStimulus(1'b1, 1'b0, 4'(8 + issued), 8'h00, 1'b1);
      if (lastAccept) issued++;
    end
    checkOutput("drainAccepted", issued, 32'd5);
    idle(6);
    checkOutput("drainRspCount", respCycles.size(), 32'd5);
    checkOutput("drainQueueEmpty", expQ.size(), 32'd0);

    // Reset with one response queued and one read in flight.
    applyStimulus(1'b1, 1'b1, 4'd3, 8'h5A, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    checkOutput("preRstRspValid", {31'd0, bus.rsp_valid}, 32'd1);
    checkOutput("preRstRspRdata", {24'd0, bus.rsp_rdata}, 32'h5A);
    rst_n = 1'b0;
    #1;
    expQ.delete();
    checkOutput("midRstRspValid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("midRstRspRdata", {24'd0, bus.rsp_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
      checkOutput("postRstNoRsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    checkOutput("postRstRdCount", {16'd0, rdCount}, 32'd0);
    checkOutput("postRstWrCount", {16'd0, wrCount}, 32'd0);
    checkOutput("postRstReqReady", {31'd0, bus.req_ready}, 32'd1);

    // Counter saturation on the narrow-counter instance.
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checkOutput("satWrCount", {28'd0, wrCountSat}, (i - 1 > 15) ? 32'd15 : 32'(i - 1));
      satBus.req_valid = 1'b1;
      satBus.req.we    = 1'b1;
      satBus.req.addr  = 4'(i);
      satBus.req.wdata = 8'(i);
    end
    @(negedge clk);
    satBus.req_valid = 1'b0;
    checkOutput("satWrCountFinal", {28'd0, wrCountSat}, 32'd15);
    @(negedge clk);
    checkOutput("satWrCountHold", {28'd0, wrCountSat}, 32'd15);
    checkOutput("satRdCount", {28'd0, rdCountSat}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Request/response front-end that sits directly upstream of the 16x8 single-port SRAM macro.
- Drives the SRAM's ADDR, WDATA and WREN, and consumes its RDATA.
- Converts a valid/ready request stream into SRAM cycles and accounts for the SRAM's 1-cycle registered read.
- Captures read data into a small response FIFO with backpressure, and keeps saturating read/write statistics counters.

Parameters:
- ADDR_WIDTH, 4, SRAM address width (16 words).
- DATA_WIDTH, 8, SRAM data width.
- RSP_DEPTH, 3, response FIFO entries. Minimum 2; 3 is needed for full read throughput.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- CLK  in  1  clock; everything is rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request accepted this cycle when REQ_VALID & REQ_READY.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  ADDR_WIDTH  request address.
- REQ_WDATA  in  DATA_WIDTH  write data.
- RSP_VALID  out  1  read response available.
- RSP_READY  in  1  consumer takes the response.
- RSP_RDATA  out  DATA_WIDTH  read data, in request order.
- SRAM_ADDR  out  ADDR_WIDTH  to SRAM ADDR.
- SRAM_WDATA  out  DATA_WIDTH  to SRAM WDATA.
- SRAM_WREN  out  1  to SRAM WREN.
- SRAM_RDATA  in  DATA_WIDTH  from SRAM RDATA.
- RD_COUNT  out  CNT_WIDTH  accepted reads, saturating.
- WR_COUNT  out  CNT_WIDTH  accepted writes, saturating.

Behaviour:
- Reset (RST_N low, async): FIFO empty, RSP_VALID=0, RSP_RDATA=0, rd_pending=0, RD_COUNT=0, WR_COUNT=0. An in-flight read is dropped, and no response is ever produced for it.
- SRAM drive, combinational:
  - SRAM_ADDR=REQ_ADDR.
  - SRAM_WDATA=REQ_WDATA.
  - SRAM_WREN=REQ_VALID & REQ_READY & REQ_WE.
  - The SRAM reads whenever WREN=0; its RDATA is unreset and changes every non-write cycle. Only the capture rule below gives it meaning.
- Credit: REQ_READY = (occ + rd_pending) < RSP_DEPTH.
  - occ = FIFO occupancy 0..RSP_DEPTH.
  - The same rule applies to reads and writes.
  - There is no combinational RSP_READY -> REQ_READY path.
- Accepted read at edge N: rd_pending<=1. At edge N+1, SRAM_RDATA is pushed into the FIFO (read latency to FIFO is 1 cycle), and rd_pending<=1 only if another read is accepted at N+1, else 0.
  - Capture at N+1 is correct whether cycle N+1 is idle, a read or a write: a write holds RDATA, and an idle/read cycle updates it only after the edge.
- Accepted write: no response. The SRAM updates at the same edge.
  - Read-then-write to the same address returns the old data.
  - Write-then-read returns the new data.
- Response output:
  - RSP_VALID = occ>0; RSP_RDATA = FIFO head.
  - Pop on RSP_VALID & RSP_READY.
  - Push and pop in the same cycle leave occ unchanged.
  - The FIFO is circular with pointers wrapping at RSP_DEPTH. It never overflows because of the credit rule. A pop on empty cannot occur.
  - Earliest RSP_VALID is 2 cycles after read acceptance: visible the cycle after the capture edge.
- Throughput: with RSP_DEPTH=3 and RSP_READY held 1, back-to-back reads sustain 1 per cycle (steady state occ=1, rd_pending=1).
- Counters: +1 per accepted read (RD_COUNT) or write (WR_COUNT). They hold at all-ones and never wrap.

Decomposition:
- Shared package sram_pkg: ADDR_WIDTH and DATA_WIDTH constants, and a request struct {we, addr, wdata}.
- One sub-module, sram_rsp_fifo: parameterised synchronous FIFO with push, pop, occ, head and async active-low reset.
- The controller holds the credit logic, rd_pending and the counters.

Test Plan:
- Reset with RST_N=0 mid-read (read of addr 3 accepted the cycle before) -> RSP_VALID=0 and RSP_RDATA=0 immediately. After release, no response appears. Counters=0 and REQ_READY=1.
- Write 0xA5 to addr 5, then read addr 5, with RSP_READY=1 -> SRAM_WREN=1 for exactly one cycle; RSP_RDATA=0xA5 with RSP_VALID high 2 cycles after the read is accepted; WR_COUNT=1, RD_COUNT=1.
- Fill addrs 0..15 with value addr*0x11, then 16 back-to-back reads with RSP_READY=1 -> REQ_READY stays 1, and 16 responses 0x00, 0x11, ..., 0xFF arrive in order on consecutive cycles.
- RSP_READY=0 while 5 reads are issued -> exactly 3 reads accepted, REQ_READY=0 thereafter with no SRAM_WREN activity. After RSP_READY=1, all 5 responses return in order with none lost or duplicated.
- Read addr 7 (old 0x3C), then write 0xC3 to addr 7 in the next cycle -> the response is 0x3C; a following read of addr 7 returns 0xC3.
- With CNT_WIDTH=4, issue 20 writes -> WR_COUNT saturates at 15 and stays 15.
